beam_scan_ctrl: RTL and testbench
=================================

BEAM_SCAN_CTRL -- requirements
Module: beam_scan_ctrl

Interface
REQ-001 Parameter NUM_DIR, 32, number of steering directions scanned (delay_select values 0..NUM_DIR-1, NUM_DIR <= 32).
REQ-002 Parameter SETTLE_FRAMES, 2, frames discarded after each delay change so the CIC pipeline can flush.
REQ-003 Parameter ACC_W, 20, energy accumulator and best_energy width.
REQ-004 Parameter RESCAN_FRAMES, 4096, idle frames between automatic rescans (used only with the macro in REQ-025).
REQ-005 clk  in  1  system clock; all logic is on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle pulse that requests a scan.
REQ-008 lr_clk  in  1  asynchronous I2S frame clock; each rising edge marks one new sample.
REQ-009 sample  in  8  signed two's-complement CIC output.
REQ-010 dwell_frames  in  4  frames accumulated per direction, minus 1 (so 0 means 1 frame and 15 means 16).
REQ-011 delay_select  out  5  steering delay driven to the beamformer.
REQ-012 best_delay  out  5  direction locked by the last completed scan.
REQ-013 best_energy  out  ACC_W  energy of best_delay from the last completed scan.
REQ-014 busy  out  1  high while a scan is in progress.
REQ-015 done  out  1  one-cycle pulse when a scan completes.

Function
REQ-016 lr_clk shall pass through a 2-flop synchronizer and rising-edge detector, giving a one-clk frame strobe 3 clks after the pin edge.
REQ-017 The FSM shall have the states IDLE, SETTLE, ACCUM, COMPARE and LOCK, with these transitions:
- IDLE->SETTLE on start: dir=0, candidate best cleared to energy 0 and index 0.
- SETTLE->ACCUM after SETTLE_FRAMES strobes: acc cleared.
- ACCUM->COMPARE after dwell_frames+1 strobes.
- COMPARE->SETTLE with dir+1 when dir < NUM_DIR-1, otherwise COMPARE->LOCK.
- LOCK->IDLE after one cycle.
REQ-018 In ACCUM, each strobe shall add sample*sample (unsigned, 15 bits, where -128 gives 16384) to acc, saturating at 2^ACC_W-1.
REQ-019 COMPARE shall replace the candidate only when acc > candidate energy (strict), so on a tie the lower index wins; COMPARE lasts exactly 1 clk.
REQ-020 delay_select shall equal dir in SETTLE, ACCUM and COMPARE, and shall equal best_delay in IDLE and LOCK.
REQ-021 In LOCK, best_delay and best_energy shall load the candidate, done shall pulse for 1 clk and busy shall fall on the next clk; both outputs are stable at all other times.
REQ-022 Boundary conditions:
- start while busy is ignored.
- A strobe coincident with start, or occurring in COMPARE or LOCK, is not counted.
- dwell_frames is sampled on entry to ACCUM; changes mid-dwell take effect at the next direction.
- sample is used only on strobe cycles.

Reset
REQ-023 rst_n low shall immediately force state IDLE and clear all of the following to 0: dir, acc, candidate, best_delay, best_energy, delay_select, busy, done and the synchronizer flops.
REQ-024 Reset mid-scan shall abandon the scan without a done pulse, and the previous best_delay shall not be retained.

Configuration
REQ-025 With BEAM_SCAN_AUTO_RESCAN_EN defined, a frame counter running in IDLE after the first completed scan shall start a new scan after RESCAN_FRAMES strobes; start also restarts the scan and resets the counter.
REQ-026 Without BEAM_SCAN_AUTO_RESCAN_EN, no rescan counter is generated and scans occur only on start.

Structure
REQ-027 The FSM state enum, the default widths (delay 5, sample 8, ACC_W) and SETTLE_FRAMES shall live in shared package supermic_pkg.
REQ-028 The synchronizer and edge detector shall be a sub-module, lr_edge_sync, reusable by the I2S path.

Verification
REQ-029 Reset: assert rst_n=0 mid-ACCUM -> all outputs 0 at once, no done pulse, and a new start runs a full scan.
REQ-030 Basic scan (NUM_DIR=4, dwell_frames=1, SETTLE_FRAMES=2), sample=10 for dir 2 and 3 otherwise -> best_delay=2, best_energy=200, done after 4*(2+2) frames plus COMPARE/LOCK cycles.
REQ-031 Tie: equal energy 50 on dir 1 and dir 3 -> best_delay=1.
REQ-032 Saturation (ACC_W=16, dwell_frames=15, sample=-128) -> acc = 65535 and does not wrap.
REQ-033 Ignored events: start pulsed while busy and a strobe coincident with start -> scan not restarted and total frame count unchanged.
REQ-034 With BEAM_SCAN_AUTO_RESCAN_EN and RESCAN_FRAMES=8 -> second scan starts (busy rises) on the 8th idle strobe; without the macro -> busy stays 0.

Source files
------------

// File: rtl/supermic_pkg.sv
// Shared types and default widths for the supermic beam scan path.
// Holds the scan FSM state enum, bus widths and the sample-square helper.
package supermic_pkg;

    localparam int DELAY_W           = 5;
    localparam int SAMPLE_W          = 8;
    localparam int SQ_W              = 15;
    localparam int DEF_ACC_W         = 20;
    localparam int DEF_SETTLE_FRAMES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_COMPARE,
        ST_LOCK
    } scan_state_e;

    // Square of a signed sample; -128 squared (16384) still fits in 15 bits.
    function automatic logic [SQ_W-1:0] sample_sq(
        input logic signed [SAMPLE_W-1:0] s
    );
        logic signed [2*SAMPLE_W-1:0] p;
        p = s * s;
        return p[SQ_W-1:0];
    endfunction

endpackage

// File: rtl/lr_edge_sync.sv
// Synchronizes an asynchronous frame clock and emits a one-clk strobe
// per rising edge. Ports: clk, rst_n, async_i (pin), strobe_o (3 clks later).
module lr_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic strobe_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic strobe_q;
    logic strobe_d;

    assign strobe_d = sync2_q & ~prev_q;
    assign strobe_o = strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= async_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            strobe_q <= strobe_d;
        end
    end

endmodule

// File: rtl/beam_scan_ctrl.sv
// Beam scan controller: sweeps steering delays, integrates per-direction
// energy over I2S frames and locks the strongest direction.
// Ports: clk, rst_n, start, lr_clk, sample, dwell_frames -> delay_select,
// best_delay, best_energy, busy, done.
// Optional macro BEAM_SCAN_AUTO_RESCAN_EN: periodic rescan while idle.
module beam_scan_ctrl
    import supermic_pkg::*;
#(
    parameter int NUM_DIR       = 32,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES,
    parameter int ACC_W         = DEF_ACC_W,
    parameter int RESCAN_FRAMES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       lr_clk,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic [3:0]                 dwell_frames,
    output logic [DELAY_W-1:0]         delay_select,
    output logic [DELAY_W-1:0]         best_delay,
    output logic [ACC_W-1:0]           best_energy,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = 8;

    scan_state_e        state_q, state_d;
    logic [DELAY_W-1:0] dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         dwell_q, dwell_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   cand_e_q, cand_e_d;
    logic [DELAY_W-1:0] cand_dir_q, cand_dir_d;
    logic [DELAY_W-1:0] best_dir_q, best_dir_d;
    logic [ACC_W-1:0]   best_e_q, best_e_d;
    logic [DELAY_W-1:0] dsel_q, dsel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               strobe;
    logic               auto_go;
    logic               go;
    logic [ACC_W:0]     sum;

    lr_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_i  (lr_clk),
        .strobe_o (strobe)
    );

`ifdef BEAM_SCAN_AUTO_RESCAN_EN
    localparam int RS_W = $clog2(RESCAN_FRAMES + 1);

    logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
    logic            armed_q, armed_d;

    // Counter only advances in IDLE once a scan has completed.
    always_comb begin
        rs_cnt_d = '0;
        armed_d  = armed_q | (state_q == ST_LOCK);
        auto_go  = 1'b0;
        if (state_q == ST_IDLE && !start) begin
            rs_cnt_d = rs_cnt_q;
            if (armed_q && strobe) begin
                if (rs_cnt_q == RS_W'(RESCAN_FRAMES - 1)) begin
                    auto_go  = 1'b1;
                    rs_cnt_d = '0;
                end else begin
                    rs_cnt_d = rs_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_cnt_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            rs_cnt_q <= rs_cnt_d;
            armed_q  <= armed_d;
        end
    end
`else
    assign auto_go = 1'b0;
`endif

    assign go  = start | auto_go;
    assign sum = {1'b0, acc_q} + (ACC_W+1)'(sample_sq(sample));

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        dwell_d    = dwell_q;
        acc_d      = acc_q;
        cand_e_d   = cand_e_q;
        cand_dir_d = cand_dir_q;
        best_dir_d = best_dir_q;
        best_e_d   = best_e_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d    = ST_SETTLE;
                    dir_d      = '0;
                    cnt_d      = '0;
                    cand_e_d   = '0;
                    cand_dir_d = '0;
                end
            end
            ST_SETTLE: begin
                if (strobe) begin
                    if (cnt_q == CNT_W'(SETTLE_FRAMES - 1)) begin
                        state_d = ST_ACCUM;
                        cnt_d   = '0;
                        acc_d   = '0;
                        dwell_d = dwell_frames;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (strobe) begin
                    // Carry out of the sum means the accumulator overflowed.
                    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                    if (cnt_q == CNT_W'(dwell_q)) begin
                        state_d = ST_COMPARE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMPARE: begin
                // Strict compare keeps the lower index on ties.
                if (acc_q > cand_e_q) begin
                    cand_e_d   = acc_q;
                    cand_dir_d = dir_q;
                end
                if (dir_q < DELAY_W'(NUM_DIR - 1)) begin
                    state_d = ST_SETTLE;
                    dir_d   = dir_q + 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d    = ST_LOCK;
                    best_dir_d = cand_dir_d;
                    best_e_d   = cand_e_d;
                    done_d     = 1'b1;
                end
            end
            ST_LOCK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_IDLE || state_d == ST_LOCK) begin
            dsel_d = best_dir_d;
        end else begin
            dsel_d = dir_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= '0;
            cnt_q      <= '0;
            dwell_q    <= '0;
            acc_q      <= '0;
            cand_e_q   <= '0;
            cand_dir_q <= '0;
            best_dir_q <= '0;
            best_e_q   <= '0;
            dsel_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            dwell_q    <= dwell_d;
            acc_q      <= acc_d;
            cand_e_q   <= cand_e_d;
            cand_dir_q <= cand_dir_d;
            best_dir_q <= best_dir_d;
            best_e_q   <= best_e_d;
            dsel_q     <= dsel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign delay_select = dsel_q;
    assign best_delay   = best_dir_q;
    assign best_energy  = best_e_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Randomized scoreboard bench for beam_scan_ctrl.
// Small configuration: 4 directions, 2 settle frames, 16-bit accumulator.
module tb_beam_scan_ctrl;

    localparam int ND  = 4;
    localparam int SF  = 2;
    localparam int AW  = 16;
    localparam int RF  = 8;
    localparam int MAXE = (1 << AW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              lr_clk = 1'b0;
    logic signed [7:0] sample;
    logic [3:0]        dwell_frames = 4'd1;
    logic [4:0]        delay_select;
    logic [4:0]        best_delay;
    logic [AW-1:0]     best_energy;
    logic              busy;
    logic              done;

    beam_scan_ctrl #(
        .NUM_DIR       (ND),
        .SETTLE_FRAMES (SF),
        .ACC_W         (AW),
        .RESCAN_FRAMES (RF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .lr_clk       (lr_clk),
        .sample       (sample),
        .dwell_frames (dwell_frames),
        .delay_select (delay_select),
        .best_delay   (best_delay),
        .best_energy  (best_energy),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dly;
        int en;
        int frames;
    } exp_t;

    exp_t              q[$];
    logic signed [7:0] tbl[ND];
    int                tests = 0;
    int                fails = 0;
    int                phase = 0;
    int                edges = 0;
    int                start_edges = 0;

    // Beamformer stand-in: the source strength depends on the steered direction.
    always_comb begin
        sample = '0;
        if (int'(delay_select) < ND) sample = tbl[delay_select[1:0]];
    end

    // Frame clock: 8 clk period, rising pin edge when phase becomes 0.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 8;
            lr_clk = (phase < 4);
            if (phase == 0) edges++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int dwell, input int frames);
        exp_t r;
        int   e;
        r.dly = 0;
        r.en = 0;
        r.frames = frames;
        for (int d = 0; d < ND; d++) begin
            e = (dwell + 1) * int'(tbl[d]) * int'(tbl[d]);
            if (e > MAXE) e = MAXE;
            if (e > r.en) begin
                r.en = e;
                r.dly = d;
            end
        end
        return r;
    endfunction

    // Monitor: each done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected none");
            end else begin
                e = q.pop_front();
                check("best_delay", int'(best_delay), e.dly);
                check("best_energy", int'(best_energy), e.en);
                check("dsel_lock", int'(delay_select), e.dly);
                if (e.frames >= 0)
                    check("scan_frames", edges - start_edges, e.frames);
            end
        end
    end

    // Start aligned with the internal strobe so the coincident one is dropped.
    task automatic issue_start();
        do begin
            @(posedge clk);
            #2;
        end while (phase != 3);
        start = 1'b1;
        start_edges = edges;
        q.push_back(model(int'(dwell_frames),
                          ND * (SF + int'(dwell_frames) + 1)));
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", name,
                     q.size());
            q.delete();
        end
    endtask

    task automatic run_scan(input string name);
        issue_start();
        wait_empty(name);
    endtask

    initial begin
        int  n;
        logic seen;

        for (int d = 0; d < ND; d++) tbl[d] = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_dsel", int'(delay_select), 0);
        check("rst_best_delay", int'(best_delay), 0);
        check("rst_best_energy", int'(best_energy), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Basic scan: strongest source on direction 2.
        tbl = '{8'sd3, 8'sd3, 8'sd10, 8'sd3};
        dwell_frames = 4'd1;
        run_scan("basic");

        // Tie between directions 1 and 3.
        tbl = '{8'sd1, 8'sd5, -8'sd1, -8'sd5};
        run_scan("tie");

        // Saturation with the largest magnitude sample.
        tbl = '{8'sd1, -8'sd128, -8'sd128, 8'sd2};
        dwell_frames = 4'd15;
        run_scan("sat");

        // Start pulsed while busy must not restart the scan.
        tbl = '{8'sd3, 8'sd3, 8'sd10, 8'sd3};
        dwell_frames = 4'd1;
        issue_start();
        repeat (37) @(posedge clk);
        #2;
        check("busy_mid", int'(busy), 1);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_empty("ign_start");

`ifndef BEAM_SCAN_AUTO_RESCAN_EN
        // No rescan logic: busy stays low while idle.
        seen = 1'b0;
        repeat (90) begin
            @(posedge clk);
            #2;
            if (busy) seen = 1'b1;
        end
        check("no_rescan", int'(seen), 0);
`endif

        // Reset in the middle of ACCUM.
        issue_start();
        n = 0;
        while (edges - start_edges < 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #3;
        check("pre_rst_best", int'(best_delay), 2);
        rst_n = 1'b0;
        #1;
        check("arst_dsel", int'(delay_select), 0);
        check("arst_best_delay", int'(best_delay), 0);
        check("arst_best_energy", int'(best_energy), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        q.delete();
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        check("post_rst_busy", int'(busy), 0);
        tbl = '{8'sd2, 8'sd9, 8'sd4, -8'sd7};
        run_scan("after_rst");

        // Randomized tables and dwell lengths.
        for (int it = 0; it < 8; it++) begin
            for (int d = 0; d < ND; d++)
                tbl[d] = 8'($urandom_range(0, 255));
            if (it == 3) tbl[2] = -tbl[0];
            dwell_frames = 4'($urandom_range(0, 15));
            run_scan("rand");
        end

`ifdef BEAM_SCAN_AUTO_RESCAN_EN
        // Automatic rescan fires on the RF-th idle strobe.
        start_edges = edges;
        q.push_back(model(int'(dwell_frames), -1));
        n = 0;
        while (!busy && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rescan_busy", int'(busy), 1);
        check("rescan_frames", edges - start_edges, RF);
        wait_empty("rescan");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
